// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time, period and duty percent of a PWM input.
// A three-flop chain conditions the asynchronous input. A small FSM times the
// high and low phases. Each completed period launches a seven-step restoring
// divider that turns high*100/period into an integer percent. A phase that
// runs TIMEOUT cycles without an edge is reported as a stuck input.
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             busy,
  output logic             stuck,
  output logic             stuck_level,
  output logic             overrun
);

  localparam int NW = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // One restoring-division step: subtract d<<i when it fits, report the quotient bit.
  function automatic logic [NW:0] div_step(input logic [NW-1:0]    r,
                                           input logic [CNT_W-1:0] d,
                                           input logic [2:0]       i);
    logic [NW-1:0] sh;
    sh = NW'(d) << i;
    if (r >= sh) div_step = {1'b1, r - sh};
    else         div_step = {1'b0, r};
  endfunction

  logic             pwm_p0, pwm_p1, pwm_p2;
  logic             rise, fall;
  logic             en_d;
  state_t           state_q, state_n;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_n;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_n;
  logic [CNT_W-1:0] period_req;
  logic             launch, timeout;

  logic [NW-1:0]    rem_q;
  logic [CNT_W-1:0] dsor_q;
  logic [CNT_W-1:0] op_hi_q, op_per_q;
  logic [6:0]       quo_q;
  logic [2:0]       it_q;
  logic [NW:0]      step;
  logic [6:0]       q_fin;
  logic             div_done;

  // Input conditioning: two synchronizer flops (pwm_p1 is s) plus a delay flop (s_d)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_p0 <= 1'b0;
      pwm_p1 <= 1'b0;
      pwm_p2 <= 1'b0;
      en_d   <= 1'b0;
    end else begin
      pwm_p0 <= pwm_in;
      pwm_p1 <= pwm_p0;
      pwm_p2 <= pwm_p1;
      en_d   <= en;
    end
  end

  assign rise = pwm_p1 & ~pwm_p2;
  assign fall = ~pwm_p1 & pwm_p2;

  // Measurement state, phase counter and latched high time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ph_cnt_q <= '0;
      hi_lat_q <= '0;
    end else begin
      state_q  <= state_n;
      ph_cnt_q <= ph_cnt_n;
      hi_lat_q <= hi_lat_n;
    end
  end

  // Phase sequencing; the edge-detect cycle counts as cycle 1 of the new phase.
  // A rise in the first enabled cycle (en_d low) is ignored.
  always_comb begin
    state_n    = state_q;
    ph_cnt_n   = ph_cnt_q;
    hi_lat_n   = hi_lat_q;
    launch     = 1'b0;
    timeout    = 1'b0;
    period_req = hi_lat_q + ph_cnt_q;
    if (!en) begin
      state_n  = IDLE;
      ph_cnt_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise && en_d) begin
            state_n  = HIGH;
            ph_cnt_n = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_lat_n = ph_cnt_q;
            state_n  = LOW;
            ph_cnt_n = CNT_ONE;
          end else if (ph_cnt_q == CNT_TO) begin
            timeout  = 1'b1;
            state_n  = IDLE;
            ph_cnt_n = '0;
          end else begin
            ph_cnt_n = ph_cnt_q + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            launch   = 1'b1;
            state_n  = HIGH;
            ph_cnt_n = CNT_ONE;
          end else if (ph_cnt_q == CNT_TO) begin
            timeout  = 1'b1;
            state_n  = IDLE;
            ph_cnt_n = '0;
          end else begin
            ph_cnt_n = ph_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_n  = IDLE;
          ph_cnt_n = '0;
        end
      endcase
    end
  end

  assign step     = div_step(rem_q, dsor_q, it_q);
  assign q_fin    = quo_q | {6'd0, step[NW]};
  assign div_done = busy & (it_q == 3'd0);

  // Divider: load on an accepted launch, then one quotient bit per cycle (bit 6 first)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      rem_q    <= '0;
      dsor_q   <= '0;
      op_hi_q  <= '0;
      op_per_q <= '0;
      quo_q    <= '0;
      it_q     <= '0;
    end else if (!en || timeout) begin
      busy <= 1'b0;
    end else if (busy) begin
      rem_q       <= step[NW-1:0];
      quo_q[it_q] <= step[NW];
      it_q        <= it_q - 3'd1;
      if (it_q == 3'd0) busy <= 1'b0;
    end else if (launch) begin
      busy     <= 1'b1;
      rem_q    <= NW'(hi_lat_q) * NW'(7'd100);
      dsor_q   <= period_req;
      op_hi_q  <= hi_lat_q;
      op_per_q <= period_req;
      quo_q    <= '0;
      it_q     <= 3'd6;
    end
  end

  // Result, stuck and overrun reporting; a timeout overrides a finishing divide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty_pct    <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        stuck   <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (rise) stuck <= 1'b0;
        if (timeout) begin
          stuck       <= 1'b1;
          stuck_level <= pwm_p1;
          duty_pct    <= pwm_p1 ? 7'd100 : 7'd0;
          valid       <= 1'b1;
        end else if (div_done) begin
          high_cnt   <= op_hi_q;
          period_cnt <= op_per_q;
          duty_pct   <= q_fin;
          valid      <= 1'b1;
        end
        if (launch && busy) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Measures an incoming PWM waveform and reports its high time, its period and its duty cycle as an integer percent. It is the receive-side counterpart of the team's PWM generator. It sits on a loop-back or external pin and lets the board check or display what the generator, or any other PWM source, is actually producing. Measurement runs continuously. Each completed period triggers a sequential divider that produces the percentage.

## Interface
- CNT_W, 16, width of the high-time and period counters.
- TIMEOUT, 1000, phase length in clk cycles without an edge that declares the input stuck. Must satisfy 2 ≤ TIMEOUT ≤ 2^(CNT_W-1)-1.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low. Clears all state and outputs.
- pwm_in  in  1  PWM input, asynchronous to clk.
- en  in  1  measurement enable, synchronous.
- high_cnt  out  CNT_W  high-phase length of the last completed period, in clk cycles.
- period_cnt  out  CNT_W  length of the last completed period, rising edge to rising edge, in clk cycles.
- duty_pct  out  7  floor(high_cnt*100/period_cnt), range 0..100.
- valid  out  1  one-cycle pulse when high_cnt, period_cnt and duty_pct update.
- busy  out  1  divider running.
- stuck  out  1  no edge seen for TIMEOUT cycles.
- stuck_level  out  1  level pwm_in was stuck at. Meaningful only while stuck=1.
- overrun  out  1  sticky: a period completed while the divider was busy, and that result was dropped.

## Operation
- **Input conditioning**
  - pwm_in passes through a 2-flop synchronizer to give s.
  - A third flop holds s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
- **Measurement FSM states:** IDLE, HIGH, LOW.
  - IDLE: waits for rise. Any partial period before the first rise is discarded. On rise, go to HIGH with ph_cnt=1.
  - HIGH: ph_cnt increments each cycle. On fall, latch hi_lat=ph_cnt, go to LOW with ph_cnt=1.
  - LOW: ph_cnt increments each cycle. On rise:
    - period = hi_lat + ph_cnt.
    - Launch the divider with (hi_lat, period).
    - Go to HIGH with ph_cnt=1.
- **Counting convention:** the edge-detect cycle counts as cycle 1 of the new phase. A clk-aligned input that is high N cycles in a period of P cycles therefore measures high_cnt=N and period_cnt=P.
- **Timeout:** in HIGH or LOW, if ph_cnt reaches TIMEOUT with no edge:
  - Set stuck=1 and stuck_level=s.
  - Set duty_pct to 100 if stuck high, 0 if stuck low.
  - Pulse valid once. high_cnt and period_cnt hold.
  - Abort any divide in progress.
  - Go to IDLE. stuck clears on the next rise.
- **Divider:** restoring divide computing Q = floor(Ndiv/D).
  - Ndiv = hi_lat*100, CNT_W+7 bits. D = period.
  - Q < 128 always, so 7 iterations suffice.
  - Iteration i = 6 down to 0: if R ≥ D<<i, then R -= D<<i and set Q[i].
- **Overrun:** a launch request while busy=1 is dropped and sets overrun. overrun clears only on reset or en=0.
- **en=0:** synchronous.
  - FSM goes to IDLE and ph_cnt clears.
  - Divider aborts: busy=0 next cycle, no valid.
  - stuck and overrun clear.
  - high_cnt, period_cnt and duty_pct hold.
- **Reset values:** high_cnt=0, period_cnt=0, duty_pct=0, valid=0, busy=0, stuck=0, stuck_level=0, overrun=0. FSM in IDLE, synchronizer flops 0.
- **Reset mid-divide:** asserting reset in any cycle of a divide kills it. No valid is produced.

## Timing
- Input-to-edge-detect latency: 3 clk cycles. This applies to both edges, so widths are preserved.
- Divider timeline, with the launching rise detected in cycle E:
  - E+1: load. busy=1 from E+1 through E+7.
  - E+1..E+7: the seven iterations.
  - E+8: high_cnt, period_cnt and duty_pct update together and valid=1 for that one cycle. busy=0.
- Minimum period with no overrun: 8 cycles. A launch in cycle E+8 is accepted.
- Timeout: valid and stuck rise in the cycle after ph_cnt reaches TIMEOUT.
- If a divide completion coincides with a timeout, the timeout wins and the divide result is discarded.
- Rise in the same cycle as en 0→1: ignored. Measurement begins at the next rise.

## Test plan
- Clock-aligned PWM, high 25 / period 50, en=1 → after the first full period, valid pulses with high_cnt=25, period_cnt=50, duty_pct=50, exactly 8 cycles after the rise detect.
- High 1 / period 3 (overrun check), then high 10 / period 40 → first: overrun=1 and no valid for the dropped periods. Second, after en toggled to clear overrun: duty_pct=25, period_cnt=40.
- High 99 / period 100, then high 0 / constant low → first: duty_pct=99 (truncated). Then, with TIMEOUT=1000, after 1000 low cycles: stuck=1, stuck_level=0, duty_pct=0, one valid pulse.
- pwm_in held high with TIMEOUT=1000 → stuck=1, stuck_level=1, duty_pct=100. Resume 30/60 PWM → stuck clears on the first rise, next valid gives duty_pct=50.
- Assert reset in cycle E+4 of a divide → all outputs 0, no valid. After release, the first valid needs two rises plus 8 cycles.
- Drop en in cycle E+3 → busy=0 next cycle, no valid, previous high_cnt/period_cnt/duty_pct hold.
